// File: rtl/dm_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dm_pkg;

    localparam int unsigned DM_DEPTH   = 3072;
    localparam int unsigned DM_LATENCY = 2;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dm_bank.sv
// Word-organised storage with byte-enabled write, write-merged combinational read
// and asynchronous clear.
module dm_bank #(
    parameter int unsigned DEPTH = 3072,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata_c
);

    logic [31:0] mem [DEPTH];

    // Selected word with the enabled store bytes already merged in
    always_comb begin
        rdata_c = mem[idx];
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    rdata_c[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= rdata_c;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle load/store responder for the MEM stage: fixed-latency, one response per request.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH   = DM_DEPTH,
    parameter int unsigned LATENCY = DM_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               do_access;

    logic               lat_we;
    logic [3:0]         lat_be;
    logic [29:0]        lat_widx;
    logic [31:0]        lat_wdata;

    logic               acc_we;
    logic [3:0]         acc_be;
    logic [29:0]        acc_widx;
    logic [31:0]        acc_wdata;
    logic               in_range;
    logic               bank_wr;
    logic [IDX_W-1:0]   bank_idx;
    logic [31:0]        bank_rdata;

    // With LATENCY == 1 the access happens on the acceptance edge, so use the live request
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_be    = req_be;
            acc_widx  = req_addr[31:2];
            acc_wdata = req_wdata;
        end else begin
            acc_we    = lat_we;
            acc_be    = lat_be;
            acc_widx  = lat_widx;
            acc_wdata = lat_wdata;
        end
        in_range = (acc_widx < 30'(DEPTH));
        bank_idx = in_range ? acc_widx[IDX_W-1:0] : '0;
        bank_wr  = do_access && in_range && acc_we;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                    end else begin
                        do_access = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_widx   <= '0;
            lat_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_be    <= req_be;
                lat_widx  <= req_addr[31:2];
                lat_wdata <= req_wdata;
            end
            if (do_access) begin
                resp_rdata <= in_range ? bank_rdata : 32'd0;
                resp_err   <= !in_range;
            end
        end
    end

    dm_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_wr),
        .be      (acc_be),
        .idx     (bank_idx),
        .wdata   (acc_wdata),
        .rdata_c (bank_rdata)
    );

`ifdef DM_TRACE_EN
    logic [31:0] lat_pc;
    logic [31:0] acc_pc;
    logic        unused_bits;

    assign acc_pc      = (state == IDLE) ? req_pc : lat_pc;
    assign unused_bits = ^req_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_pc <= '0;
        end else if (state == IDLE && req_valid) begin
            lat_pc <= req_pc;
        end
    end

    // One line per in-range store that actually touches a byte
    always_ff @(posedge clk) begin
        if (reset && bank_wr && (|acc_be)) begin
            $display("@%08h: *%08h <= %08h", acc_pc, {acc_widx, 2'b00}, bank_rdata);
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{req_pc, req_addr[1:0]};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed cases plus randomized traffic against a word-array model.
module tb_dm_responder;

    localparam int unsigned DEPTH   = 3072;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    dm_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'd0;
    endtask

    // Expected response from the word-array view of memory
    task automatic model_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp_d, output logic exp_e);
        int unsigned idx;
        idx = addr >> 2;
        if (idx >= DEPTH) begin
            exp_d = 32'd0;
            exp_e = 1'b1;
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            exp_d = mem_m[idx];
            exp_e = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Called just after the acceptance edge; returns at the negedge of the response cycle
    task automatic wait_resp(input string tag, input logic [31:0] exp_d, input logic exp_e);
        int lat = 0;
        int rdy_seen = 0;
        while (lat < int'(LATENCY) + 5) begin
            @(negedge clk);
            lat++;
            if (req_ready) rdy_seen++;
            if (resp_valid) break;
        end
        check({tag, "_lat"},  32'(lat), 32'(LATENCY));
        check({tag, "_busy"}, 32'(rdy_seen), 32'd0);
        check({tag, "_data"}, resp_rdata, exp_d);
        check({tag, "_err"},  32'(resp_err), 32'(exp_e));
    endtask

    task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_d;
        logic        exp_e;
        wait_ready(tag);
        model_access(we, be, addr, wdata, exp_d, exp_e);
        drive(we, be, addr, wdata, 32'h0000_1000);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(tag, exp_d, exp_e);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdy"},   32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_e;
        logic [29:0] widx;
        logic [31:0] addr;
        int          sel;
        int          rv_seen;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_pc    = 32'd0;
        model_clear();

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err",   32'(resp_err), 32'd0);
        do_req("ld_rst", 1'b0, 4'hF, 32'h0000_0010, 32'd0);

        // Word and lane stores
        do_req("st_word", 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        do_req("ld_word", 1'b0, 4'h0, 32'h0000_0010, 32'd0);
        check("word_val", resp_rdata, 32'hDEAD_BEEF);
        do_req("st_b1",   1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500);
        check("b1_val", resp_rdata, 32'hDEAD_55EF);
        do_req("st_h1",   1'b1, 4'b1100, 32'h0000_0010, 32'h1234_0000);
        check("h1_val", resp_rdata, 32'h1234_55EF);

        // Out of range, then confirm nothing moved
        do_req("ld_oob", 1'b0, 4'hF, 32'h0000_3000, 32'd0);
        check("oob_err", 32'(resp_err), 32'd1);
        do_req("st_oob", 1'b1, 4'hF, 32'h0000_3000, 32'hFFFF_FFFF);
        do_req("ld_w0",  1'b0, 4'hF, 32'h0000_0000, 32'd0);
        do_req("ld_w4",  1'b0, 4'hF, 32'h0000_0010, 32'd0);
        do_req("ld_top", 1'b0, 4'hF, 32'h0000_2FFC, 32'd0);

        // Store with no enables returns current word
        do_req("st_be0", 1'b1, 4'h0, 32'h0000_0010, 32'hAAAA_AAAA);
        check("be0_val", resp_rdata, 32'h1234_55EF);

        // Trace candidate store
        wait_ready("trace");
        model_access(1'b1, 4'b0001, 32'h0000_0008, 32'h0000_0011, exp_d, exp_e);
        drive(1'b1, 4'b0001, 32'h0000_0008, 32'h0000_0011, 32'h0000_3004);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp("trace", exp_d, exp_e);
        @(negedge clk);

        // Request held through WAIT/RESP must not be taken twice
        wait_ready("busyA");
        model_access(1'b1, 4'hF, 32'h0000_0050, 32'h0102_0304, exp_d, exp_e);
        drive(1'b1, 4'hF, 32'h0000_0050, 32'h0102_0304, 32'h0);
        @(posedge clk);
        #1 drive(1'b1, 4'b0011, 32'h0000_0050, 32'hCAFE_F00D, 32'h0);
        wait_resp("busyA", exp_d, exp_e);
        @(negedge clk);
        check("busy_rdy", 32'(req_ready), 32'd1);
        model_access(1'b1, 4'b0011, 32'h0000_0050, 32'hCAFE_F00D, exp_d, exp_e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp("busyB", exp_d, exp_e);
        check("busyB_val", resp_rdata, 32'h0102_F00D);
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      widx = 30'($urandom_range(0, 15));
            else if (sel == 7) widx = 30'($urandom_range(DEPTH - 4, DEPTH - 1));
            else if (sel == 8) widx = 30'($urandom_range(DEPTH, DEPTH + 8));
            else               widx = 30'($urandom);
            addr = {widx, 2'($urandom)};
            do_req("rnd", 1'($urandom), 4'($urandom), addr, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during WAIT of a store discards it
        wait_ready("abort");
        drive(1'b1, 4'hF, 32'h0000_0010, 32'hAAAA_5555, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rdy",   32'(req_ready), 32'd1);
        check("abort_valid", 32'(resp_valid), 32'd0);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        reset = 1'b1;
        model_clear();
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        check("abort_noresp", 32'(rv_seen), 32'd0);
        do_req("abort_ld", 1'b0, 4'hF, 32'h0000_0010, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
